// File: rtl/btn_led_ctrl.sv
// Multi-channel push-button front end: synchronise, debounce and edge-detect each
// button, then drive one LED per channel in toggle, momentary, blink or one-shot mode.
module btn_led_ctrl #(
  parameter int NUM_CH          = 3,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int BLINK_CYCLES    = 3000000,
  parameter int PULSE_CYCLES    = 1200000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_CH-1:0]     btn_i,
  input  logic [2*NUM_CH-1:0]   mode_i,
  output logic [NUM_CH-1:0]     led_o,
  output logic [NUM_CH-1:0]     press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PUL_LOAD = PW'(PULSE_CYCLES);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_TOGGLE    = 2'b00,
    MODE_MOMENTARY = 2'b01,
    MODE_BLINK     = 2'b10,
    MODE_ONESHOT   = 2'b11
  } mode_e;

  // Shared free-running blink phase; every blinking channel stays in step with it.
  logic [BW-1:0] blk_q;
  logic          ph_q;
  logic          blk_wrap;
  logic          ph_d;

  assign blk_wrap = (blk_q == BLK_LAST);
  assign ph_d     = ph_q ^ blk_wrap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      blk_q <= blk_wrap ? '0 : blk_q + BW'(1);
      ph_q  <= ph_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_prev_q;
    logic          tog_q;
    logic          led_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] pul_q;
    logic [PW-1:0] pul_d;
    logic          press;
    logic          tog_d;
    logic          led_d;
    mode_e         mode;

    assign mode  = mode_e'(mode_i[2*c +: 2]);
    assign press = db_q & ~db_prev_q;
    assign tog_d = tog_q ^ press;

    // A press reloads the pulse timer even if it is still running (retrigger).
    always_comb begin
      pul_d = pul_q;
      if (press) begin
        pul_d = PUL_LOAD;
      end else if (pul_q != '0) begin
        pul_d = pul_q - PW'(1);
      end
    end

    always_comb begin
      led_d = 1'b0;
      case (mode)
        MODE_TOGGLE:    led_d = tog_d;
        MODE_MOMENTARY: led_d = db_q;
        MODE_BLINK:     led_d = tog_d & ph_d;
        MODE_ONESHOT:   led_d = (pul_d != '0);
        default:        led_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
        tog_q     <= 1'b0;
        pul_q     <= '0;
        led_q     <= 1'b0;
      end else begin
        sync1_q   <= btn_i[c];
        sync2_q   <= sync1_q;
        db_prev_q <= db_q;
        // Any return to the accepted level throws away the partial count.
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        tog_q <= tog_d;
        pul_q <= pul_d;
        led_q <= led_d;
      end
    end

    assign led_o[c]   = led_q;
    assign press_o[c] = press;
  end

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl: two instances (slow and minimum-parameter) checked
// every cycle against a timestamp/count based model, plus hand-computed literal checks.
module tb_btn_led_ctrl;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic [2:0] btn    = 3'b000;
  logic [2:0] btn_b  = 3'b000;
  logic [5:0] mode   = 6'b000000;
  logic [5:0] mode_b = 6'b100111;
  logic [2:0] led_a, press_a, led_b, press_b;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  logic [2:0] press_acc;
  int cnt_a0, cnt_a2, cnt_b0;

  always #5 clk_i = ~clk_i;

  btn_led_ctrl #(.NUM_CH(3), .DEBOUNCE_CYCLES(4), .BLINK_CYCLES(5), .PULSE_CYCLES(3)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn), .mode_i(mode),
    .led_o(led_a), .press_o(press_a)
  );

  btn_led_ctrl #(.NUM_CH(3), .DEBOUNCE_CYCLES(1), .BLINK_CYCLES(1), .PULSE_CYCLES(6)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_b), .mode_i(mode_b),
    .led_o(led_b), .press_o(press_b)
  );

  // ---------------- behavioural model ----------------
  // Index 0 models u_dut, index 1 models u_dut_b.
  int         edge_n [2];
  int         run_m  [2][3];
  bit         db_m   [2][3];
  bit         pv_m   [2][3];
  int         np_m   [2][3];
  int         lastp_m[2][3];
  logic [2:0] h1_m[2], h2_m[2];
  logic [2:0] exp_led[2], exp_press[2];

  function automatic int p_deb(input int i);   return (i == 0) ? 4 : 1; endfunction
  function automatic int p_blk(input int i);   return (i == 0) ? 5 : 1; endfunction
  function automatic int p_pul(input int i);   return (i == 0) ? 3 : 6; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      edge_n[i]    = 0;
      h1_m[i]      = 3'b000;
      h2_m[i]      = 3'b000;
      exp_led[i]   = 3'b000;
      exp_press[i] = 3'b000;
      for (int c = 0; c < 3; c++) begin
        run_m[i][c]   = 0;
        db_m[i][c]    = 1'b0;
        pv_m[i][c]    = 1'b0;
        np_m[i][c]    = 0;
        lastp_m[i][c] = -1000;
      end
    end
  endtask

  // One clock edge: presses seen, edges since reset and last press time drive the LEDs.
  task automatic model_step(input int i, input logic [2:0] b, input logic [5:0] m);
    int n;
    bit db_old;
    bit sy;
    bit tog;
    bit ph;
    logic [1:0] mc;
    edge_n[i] = edge_n[i] + 1;
    n = edge_n[i];
    ph = ((n / p_blk(i)) % 2) == 1;
    for (int c = 0; c < 3; c++) begin
      if (pv_m[i][c]) begin
        np_m[i][c]    = np_m[i][c] + 1;
        lastp_m[i][c] = n;
      end
      tog = (np_m[i][c] % 2) == 1;
      mc  = m[2*c +: 2];
      case (mc)
        2'b00:   exp_led[i][c] = tog;
        2'b01:   exp_led[i][c] = db_m[i][c];
        2'b10:   exp_led[i][c] = tog & ph;
        default: exp_led[i][c] = (n - lastp_m[i][c]) < p_pul(i);
      endcase
      db_old = db_m[i][c];
      sy     = h2_m[i][c];
      if (sy != db_m[i][c]) begin
        run_m[i][c] = run_m[i][c] + 1;
        if (run_m[i][c] == p_deb(i)) begin
          db_m[i][c]  = sy;
          run_m[i][c] = 0;
        end
      end else begin
        run_m[i][c] = 0;
      end
      pv_m[i][c]      = db_m[i][c] & ~db_old;
      exp_press[i][c] = pv_m[i][c];
    end
    h2_m[i] = h1_m[i];
    h1_m[i] = b;
  endtask

  initial forever begin
    @(posedge clk_i);
    if (!rst_ni) begin
      model_reset();
    end else begin
      model_step(0, btn, mode);
      model_step(1, btn_b, mode_b);
    end
  end

  initial forever begin
    @(negedge rst_ni);
    model_reset();
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      cmp("led_a",   led_a,   exp_led[0]);
      cmp("press_a", press_a, exp_press[0]);
      cmp("led_b",   led_b,   exp_led[1]);
      cmp("press_b", press_b, exp_press[1]);
    end
    press_acc = press_acc | press_a;
    if (led_a[0]) cnt_a0 = cnt_a0 + 1;
    if (led_a[2]) cnt_a2 = cnt_a2 + 1;
    if (led_b[0]) cnt_b0 = cnt_b0 + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic set_btn(input logic [2:0] v);
    btn   = v;
    btn_b = v;
  endtask

  task automatic clr_acc();
    press_acc = 3'b000;
    cnt_a0 = 0;
    cnt_a2 = 0;
    cnt_b0 = 0;
  endtask

  initial begin
    model_reset();
    clr_acc();
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    cmp("rst_led", led_a, 3'b000);
    cmp("rst_press", press_a, 3'b000);
    rst_ni = 1'b1;
    cyc(2);

    // Bounce rejection on ch0, toggle mode
    clr_acc();
    set_btn(3'b001); cyc(3);
    set_btn(3'b000); cyc(2);
    set_btn(3'b001); cyc(3);
    set_btn(3'b000); cyc(12);
    cmp("bounce_no_press", press_acc, 3'b000);
    cmp("bounce_led", led_a, 3'b000);

    set_btn(3'b001); cyc(6);
    cmp("press_edge6", press_a, 3'b001);
    cmp("led_before_edge7", led_a, 3'b000);
    cyc(1);
    cmp("press_edge7", press_a, 3'b000);
    cmp("led_edge7", led_a, 3'b001);
    set_btn(3'b000); cyc(10);
    cmp("led_after_release", led_a, 3'b001);

    // Asynchronous reset mid-cycle with ch0 LED lit
    #1 rst_ni = 1'b0;
    #1;
    cmp("async_rst_led", led_a, 3'b000);
    cmp("async_rst_press", press_a, 3'b000);
    cyc(3);
    rst_ni = 1'b1;
    cyc(10);
    cmp("post_rst_led", led_a, 3'b000);
    cmp("post_rst_press", press_a, 3'b000);

    // Press, release, re-press toggles ch0 back off
    set_btn(3'b001); cyc(7);
    cmp("toggle_on", led_a, 3'b001);
    set_btn(3'b000); cyc(10);
    set_btn(3'b001); cyc(7);
    cmp("toggle_off", led_a, 3'b000);
    set_btn(3'b000); cyc(10);

    // Momentary ch1
    mode = 6'b000100;
    set_btn(3'b010); cyc(6);
    cmp("mom_press", press_a, 3'b010);
    cyc(1);
    cmp("mom_led_on", led_a, 3'b010);
    cyc(13);
    set_btn(3'b000); cyc(6);
    cmp("mom_led_hold", led_a, 3'b010);
    cyc(1);
    cmp("mom_led_off", led_a, 3'b000);

    // Blink-toggle ch2
    mode = 6'b100100;
    set_btn(3'b100); cyc(10);
    set_btn(3'b000); cyc(10);
    clr_acc();
    cyc(10);
    cmp("blink_high_count", 3'(cnt_a2), 3'd5);
    set_btn(3'b100); cyc(10);
    set_btn(3'b000); cyc(10);
    clr_acc();
    cyc(12);
    cmp("blink_off_count", 3'(cnt_a2), 3'd0);

    // One-shot ch0 on the slow instance
    mode = 6'b100111;
    cyc(2);
    clr_acc();
    btn = 3'b001; cyc(20);
    cmp("oneshot_count", 3'(cnt_a0), 3'd3);
    btn = 3'b000; cyc(10);

    // Retrigger on the fast instance: presses land at edges 4 and 8
    clr_acc();
    btn_b = 3'b001; cyc(2);
    btn_b = 3'b000; cyc(2);
    btn_b = 3'b001; cyc(2);
    btn_b = 3'b000; cyc(19);
    cmp("retrigger_count", 4'(cnt_b0), 4'd10);

    // Simultaneous presses and mode change
    #1 rst_ni = 1'b0;
    cyc(2);
    rst_ni = 1'b1;
    mode = 6'b000000;
    cyc(2);
    set_btn(3'b111); cyc(6);
    cmp("simul_press", press_a, 3'b111);
    cyc(1);
    cmp("simul_led", led_a, 3'b111);
    cmp("simul_press_gone", press_a, 3'b000);
    set_btn(3'b000); cyc(10);
    mode = 6'b000001; cyc(1);
    cmp("mode_to_mom", led_a, 3'b110);
    mode = 6'b000000; cyc(1);
    cmp("mode_back", led_a, 3'b111);
    cyc(5);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
